// File: rtl/cu_fsm_mc_if.sv
// Signal bundle between the multicycle control unit and the rest of the OTTER
// (decoder, PC, register file, CSR file, memory).
//
// Memory handshake: a request is a strobe (FSM_memRDEN1, FSM_memRDEN2 or
// FSM_memWE2) that the control unit holds high cycle after cycle. mem_ack is
// the ready: the request completes at the rising edge where the strobe and
// mem_ack are both high. mem_ack has no meaning when no strobe is high. A
// request never drops before its ack, except on bus-error timeout or reset.
interface cu_fsm_mc_if #(
  parameter int NUM_IRQ = 4
);
  localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  // decoder / CSR / interrupt inputs to the control unit
  logic [6:0]         FSM_opcode;
  logic [2:0]         FSM_funct3;
  logic [NUM_IRQ-1:0] FSM_irq;
  logic [NUM_IRQ-1:0] FSM_irq_mask;
  logic               FSM_mie;
  logic               mem_ack;

  // control strobes
  logic               FSM_pcWrite;
  logic               FSM_regWrite;
  logic               FSM_memWE2;
  logic               FSM_memRDEN1;
  logic               FSM_memRDEN2;
  logic               FSM_reset;
  logic               csr_WE;
  logic               int_taken;
  logic [CW-1:0]      int_cause;
  logic               mret_exec;
  logic               trap_taken;
  logic [1:0]         trap_cause;
  logic [2:0]         state_dbg;

  // control unit side
  modport master (
    input  FSM_opcode, FSM_funct3, FSM_irq, FSM_irq_mask, FSM_mie, mem_ack,
    output FSM_pcWrite, FSM_regWrite, FSM_memWE2, FSM_memRDEN1, FSM_memRDEN2,
           FSM_reset, csr_WE, int_taken, int_cause, mret_exec, trap_taken,
           trap_cause, state_dbg
  );

  // datapath / memory side
  modport slave (
    output FSM_opcode, FSM_funct3, FSM_irq, FSM_irq_mask, FSM_mie, mem_ack,
    input  FSM_pcWrite, FSM_regWrite, FSM_memWE2, FSM_memRDEN1, FSM_memRDEN2,
           FSM_reset, csr_WE, int_taken, int_cause, mret_exec, trap_taken,
           trap_cause, state_dbg
  );
endinterface

// File: rtl/cu_fsm_mc.sv
// Multicycle control unit for the RISC-V OTTER with memory wait states,
// bus-error timeout, prioritised maskable interrupts and illegal-instruction
// traps. Strobes decode from the present state; int_cause and trap_cause are
// registered and hold until the next interrupt / trap entry.
module cu_fsm_mc #(
  parameter int NUM_IRQ         = 4,
  parameter int MEM_TIMEOUT     = 15,
  parameter bit ILLEGAL_TRAP_EN = 1'b1
) (
  input logic        FSM_clk,
  input logic        FSM_RST_n,
  cu_fsm_mc_if.master bus
);
  localparam int CW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_VAL = TW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_WB       = 3'd4,
    S_INTR     = 3'd5,
    S_TRAP     = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          is_store_q, is_store_d;
  logic [CW-1:0] int_cause_q, int_cause_d;
  logic [1:0]    trap_cause_q, trap_cause_d;

  logic pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, fsm_reset;
  logic csr_we, int_taken, mret_exec, trap_taken;
  logic eoi, illegal, timeout, pend;
  logic [NUM_IRQ-1:0] irq_req;
  logic [CW-1:0]      irq_idx;

  // Lowest-numbered enabled request wins.
  always_comb begin
    irq_req = bus.FSM_irq & bus.FSM_irq_mask;
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) irq_idx = CW'(i);
    end
  end

  // Next-state, strobe decode, wait counter and cause capture.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    is_store_d   = is_store_q;
    int_cause_d  = int_cause_q;
    trap_cause_d = trap_cause_q;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    mem_we2      = 1'b0;
    mem_rden1    = 1'b0;
    mem_rden2    = 1'b0;
    fsm_reset    = 1'b0;
    csr_we       = 1'b0;
    int_taken    = 1'b0;
    mret_exec    = 1'b0;
    trap_taken   = 1'b0;
    eoi          = 1'b0;
    illegal      = 1'b0;
    // Counter value MEM_TIMEOUT means that many ack-less cycles have already
    // passed; the request is abandoned in this cycle even if ack shows up now.
    timeout      = (MEM_TIMEOUT > 0) && (wait_cnt_q == TO_VAL);
    pend         = bus.FSM_mie & (|irq_req);

    case (state_q)
      S_INIT: begin
        fsm_reset = 1'b1;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        mem_rden1 = 1'b1;
        if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end else if (bus.mem_ack) begin
          state_d = S_EXEC;
        end else if (MEM_TIMEOUT > 0) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        case (bus.FSM_opcode)
          OP_OP, OP_IMM, OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: begin
            pc_write  = 1'b1;
            reg_write = 1'b1;
            eoi       = 1'b1;
          end
          OP_BRANCH: begin
            pc_write = 1'b1;
            eoi      = 1'b1;
          end
          OP_SYSTEM: begin
            if (bus.FSM_funct3 == 3'b000) begin
              pc_write  = 1'b1;
              mret_exec = 1'b1;
              eoi       = 1'b1;
            end else if (bus.FSM_funct3 != 3'b100) begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
              csr_we    = 1'b1;
              eoi       = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          OP_LOAD: begin
            mem_rden2  = 1'b1;
            is_store_d = 1'b0;
            state_d    = bus.mem_ack ? S_WB : S_MEM_WAIT;
          end
          OP_STORE: begin
            mem_we2    = 1'b1;
            is_store_d = 1'b1;
            if (bus.mem_ack) begin
              pc_write = 1'b1;
              eoi      = 1'b1;
            end else begin
              state_d = S_MEM_WAIT;
            end
          end
          default: illegal = 1'b1;
        endcase
        if (illegal) begin
          if (ILLEGAL_TRAP_EN) begin
            state_d      = S_TRAP;
            trap_cause_d = 2'b01;
          end else begin
            fsm_reset = 1'b1;
            state_d   = S_INIT;
          end
        end
      end
      S_MEM_WAIT: begin
        mem_we2   = is_store_q;
        mem_rden2 = ~is_store_q;
        if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'b10;
        end else if (bus.mem_ack) begin
          if (is_store_q) begin
            pc_write = 1'b1;
            eoi      = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (MEM_TIMEOUT > 0) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_WB: begin
        pc_write  = 1'b1;
        reg_write = 1'b1;
        eoi       = 1'b1;
      end
      S_INTR: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        trap_taken = 1'b1;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase

    // Interrupts are only considered at an instruction boundary.
    if (eoi) begin
      if (pend) begin
        state_d     = S_INTR;
        int_cause_d = irq_idx;
      end else begin
        state_d = S_FETCH;
      end
    end
  end

  // State, counter, store flag and cause registers.
  always_ff @(posedge FSM_clk) begin
    if (!FSM_RST_n) begin
      state_q      <= S_INIT;
      wait_cnt_q   <= '0;
      is_store_q   <= 1'b0;
      int_cause_q  <= '0;
      trap_cause_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      is_store_q   <= is_store_d;
      int_cause_q  <= int_cause_d;
      trap_cause_q <= trap_cause_d;
    end
  end

  assign bus.FSM_pcWrite  = pc_write;
  assign bus.FSM_regWrite = reg_write;
  assign bus.FSM_memWE2   = mem_we2;
  assign bus.FSM_memRDEN1 = mem_rden1;
  assign bus.FSM_memRDEN2 = mem_rden2;
  assign bus.FSM_reset    = fsm_reset;
  assign bus.csr_WE       = csr_we;
  assign bus.int_taken    = int_taken;
  assign bus.int_cause    = int_cause_q;
  assign bus.mret_exec    = mret_exec;
  assign bus.trap_taken   = trap_taken;
  assign bus.trap_cause   = trap_cause_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_cu_fsm_mc.sv
// Bench for cu_fsm_mc. Two instances share the same stimulus: dut_a with the
// default configuration (timeout 15, illegal -> TRAP) and dut_b with timeout 3
// and legacy illegal handling. Only the selected instance is compared.
// The reference model expands each instruction into its expected per-cycle
// output trace (plus the mem_ack value to drive on that cycle).
module tb_cu_fsm_mc;
  localparam int W = 18;  // {ack, state[2:0], strobes[9:0], int_cause[1:0], trap_cause[1:0]}

  localparam logic [9:0] S_PCW  = 10'h200;
  localparam logic [9:0] S_RW   = 10'h100;
  localparam logic [9:0] S_WE2  = 10'h080;
  localparam logic [9:0] S_RD1  = 10'h040;
  localparam logic [9:0] S_RD2  = 10'h020;
  localparam logic [9:0] S_RST  = 10'h010;
  localparam logic [9:0] S_CSR  = 10'h008;
  localparam logic [9:0] S_IT   = 10'h004;
  localparam logic [9:0] S_MRET = 10'h002;
  localparam logic [9:0] S_TT   = 10'h001;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] irq, irq_mask;
  logic       mie, mem_ack;

  cu_fsm_mc_if #(.NUM_IRQ(4)) bus_a ();
  cu_fsm_mc_if #(.NUM_IRQ(4)) bus_b ();

  assign bus_a.FSM_opcode   = opcode;
  assign bus_a.FSM_funct3   = funct3;
  assign bus_a.FSM_irq      = irq;
  assign bus_a.FSM_irq_mask = irq_mask;
  assign bus_a.FSM_mie      = mie;
  assign bus_a.mem_ack      = mem_ack;
  assign bus_b.FSM_opcode   = opcode;
  assign bus_b.FSM_funct3   = funct3;
  assign bus_b.FSM_irq      = irq;
  assign bus_b.FSM_irq_mask = irq_mask;
  assign bus_b.FSM_mie      = mie;
  assign bus_b.mem_ack      = mem_ack;

  cu_fsm_mc #(.NUM_IRQ(4), .MEM_TIMEOUT(15), .ILLEGAL_TRAP_EN(1'b1)) dut_a (
    .FSM_clk(clk), .FSM_RST_n(rst_n), .bus(bus_a.master)
  );
  cu_fsm_mc #(.NUM_IRQ(4), .MEM_TIMEOUT(3), .ILLEGAL_TRAP_EN(1'b0)) dut_b (
    .FSM_clk(clk), .FSM_RST_n(rst_n), .bus(bus_b.master)
  );

  wire [16:0] obs_a = {bus_a.state_dbg, bus_a.FSM_pcWrite, bus_a.FSM_regWrite,
                       bus_a.FSM_memWE2, bus_a.FSM_memRDEN1, bus_a.FSM_memRDEN2,
                       bus_a.FSM_reset, bus_a.csr_WE, bus_a.int_taken,
                       bus_a.mret_exec, bus_a.trap_taken, bus_a.int_cause,
                       bus_a.trap_cause};
  wire [16:0] obs_b = {bus_b.state_dbg, bus_b.FSM_pcWrite, bus_b.FSM_regWrite,
                       bus_b.FSM_memWE2, bus_b.FSM_memRDEN1, bus_b.FSM_memRDEN2,
                       bus_b.FSM_reset, bus_b.csr_WE, bus_b.int_taken,
                       bus_b.mret_exec, bus_b.trap_taken, bus_b.int_cause,
                       bus_b.trap_cause};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int sel = 0;

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h (state %0d) exp=%h (state %0d)",
               tag, got, got[16:14], exp, exp[16:14]);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_to;
  bit         m_trap_en;
  logic [1:0] m_int_cause, m_trap_cause;

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic ack, input int st, input logic [9:0] s);
    exp_q.push_back({ack, 3'(st), s, m_int_cause, m_trap_cause});
  endtask

  task automatic trap(input logic [1:0] c);
    m_trap_cause = c;
    push(rnd_bit(), 6, S_PCW | S_TT);
  endtask

  task automatic end_instr(input logic [3:0] irq_v, input logic [3:0] msk, input logic mie_v);
    logic [3:0] r;
    r = irq_v & msk;
    if (mie_v && (r != 4'd0)) begin
      for (int k = 0; k < 4; k++) begin
        if (r[k]) begin
          m_int_cause = 2'(k);
          break;
        end
      end
      push(rnd_bit(), 5, S_PCW | S_IT);
    end
  endtask

  // One memory access after its first cycle: dm = ack-less cycles counting the
  // first one. Returns 1 when the access completed, 0 on bus-error trap.
  task automatic mem_wait(input int dm, input logic [9:0] strobe, input bit store, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (m_to > 0 && i == m_to) begin
        push(logic'(i + 1 == dm), 3, strobe);
        trap(2'b10);
        return;
      end
      if (i + 1 == dm) begin
        push(1'b1, 3, store ? (strobe | S_PCW) : strobe);
        ok = 1'b1;
        return;
      end
      push(1'b0, 3, strobe);
    end
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input int df, input int dm,
                       input logic [3:0] irq_v, input logic [3:0] msk, input logic mie_v);
    bit ok;
    // instruction fetch
    for (int i = 0; i < 1000; i++) begin
      if (m_to > 0 && i == m_to) begin
        push(logic'(i == df), 1, S_RD1);
        trap(2'b10);
        return;
      end
      if (i == df) begin
        push(1'b1, 1, S_RD1);
        break;
      end
      push(1'b0, 1, S_RD1);
    end
    // execute
    if (op inside {7'h33, 7'h13, 7'h67, 7'h37, 7'h17, 7'h6F}) begin
      push(rnd_bit(), 2, S_PCW | S_RW);
      end_instr(irq_v, msk, mie_v);
    end else if (op == 7'h63) begin
      push(rnd_bit(), 2, S_PCW);
      end_instr(irq_v, msk, mie_v);
    end else if (op == 7'h73 && f3 == 3'd0) begin
      push(rnd_bit(), 2, S_PCW | S_MRET);
      end_instr(irq_v, msk, mie_v);
    end else if (op == 7'h73 && f3 != 3'd4) begin
      push(rnd_bit(), 2, S_PCW | S_RW | S_CSR);
      end_instr(irq_v, msk, mie_v);
    end else if (op == 7'h03) begin
      push(logic'(dm == 0), 2, S_RD2);
      ok = 1'b1;
      if (dm > 0) mem_wait(dm, S_RD2, 1'b0, ok);
      if (ok) begin
        push(rnd_bit(), 4, S_PCW | S_RW);
        end_instr(irq_v, msk, mie_v);
      end
    end else if (op == 7'h23) begin
      push(logic'(dm == 0), 2, (dm == 0) ? (S_WE2 | S_PCW) : S_WE2);
      ok = 1'b1;
      if (dm > 0) mem_wait(dm, S_WE2, 1'b1, ok);
      if (ok) end_instr(irq_v, msk, mie_v);
    end else begin
      if (m_trap_en) begin
        push(rnd_bit(), 2, 10'd0);
        trap(2'b01);
      end else begin
        push(rnd_bit(), 2, S_RST);
        push(rnd_bit(), 0, S_RST);
      end
    end
  endtask

  // ---------------- driver ----------------
  logic [6:0] p_op;
  logic [2:0] p_f3;
  logic [3:0] p_irq, p_msk;
  logic       p_mie;

  // Instruction inputs change just after the edge that starts its fetch, so
  // the previous instruction's end-of-instruction sampling is undisturbed.
  task automatic drain(input int max_cyc);
    logic [W-1:0] e;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < max_cyc) begin
      e = exp_q.pop_front();
      @(posedge clk);
      #1;
      if (n == 0) begin
        opcode = p_op; funct3 = p_f3; irq = p_irq; irq_mask = p_msk; mie = p_mie;
      end
      mem_ack = e[W-1];
      @(negedge clk);
      check($sformatf("cyc%0d", cyc), (sel != 0) ? obs_b : obs_a, e[W-2:0]);
      cyc++;
      n++;
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int df, input int dm,
                           input logic [3:0] irq_v, input logic [3:0] msk, input logic mie_v,
                           input int max_cyc);
    p_op = op; p_f3 = f3; p_irq = irq_v; p_msk = msk; p_mie = mie_v;
    build(op, f3, df, dm, irq_v, msk, mie_v);
    drain(max_cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    m_int_cause = 2'b00;
    m_trap_cause = 2'b00;
    check("reset_init", (sel != 0) ? obs_b : obs_a, {3'd0, S_RST, 2'b00, 2'b00});
  endtask

  task automatic run_random(input int count);
    logic [6:0] ops[12];
    int df, dm;
    ops = '{7'h33, 7'h13, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h63, 7'h73, 7'h03, 7'h23, 7'h00, 7'h7F};
    for (int t = 0; t < count; t++) begin
      df = ($urandom_range(0, 9) == 0) ? $urandom_range(m_to - 1, m_to + 2) : $urandom_range(0, 3);
      dm = ($urandom_range(0, 7) == 0) ? $urandom_range(m_to, m_to + 3) : $urandom_range(0, 4);
      run_instr(ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)), df, dm,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), rnd_bit(), 1000);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; opcode = 7'h13; funct3 = 3'd0; irq = 4'd0; irq_mask = 4'd0;
    mie = 1'b0; mem_ack = 1'b0;

    // dut_a: timeout 15, illegal traps
    sel = 0; m_to = 15; m_trap_en = 1'b1;
    do_reset();
    run_instr(7'b0010011, 3'd0, 0, 0, 4'b0000, 4'b0000, 1'b0, 1000);  // addi
    run_instr(7'b0000011, 3'd2, 0, 3, 4'b0000, 4'b0000, 1'b0, 1000);  // lw, 3 wait
    run_instr(7'b0100011, 3'd2, 1, 1, 4'b0000, 4'b0000, 1'b0, 1000);  // sw, ack cycle 2
    run_instr(7'b0110011, 3'd0, 0, 0, 4'b1010, 4'b1110, 1'b1, 1000);  // add + irq 1
    run_instr(7'b0110011, 3'd0, 0, 0, 4'b1010, 4'b1110, 1'b0, 1000);  // mie=0
    run_instr(7'b0110011, 3'd0, 20, 0, 4'b1111, 4'b1111, 1'b1, 1000); // fetch timeout
    run_instr(7'b0110011, 3'd0, 15, 0, 4'b0000, 4'b0000, 1'b0, 1000); // late ack loses
    run_instr(7'b0110011, 3'd0, 14, 0, 4'b0000, 4'b0000, 1'b0, 1000); // ack just in time
    run_instr(7'b0000000, 3'd0, 0, 0, 4'b1000, 4'b1000, 1'b1, 1000);  // illegal
    run_instr(7'b1110011, 3'd4, 0, 0, 4'b0000, 4'b0000, 1'b0, 1000);  // csr f3=100
    run_instr(7'b1110011, 3'd1, 0, 0, 4'b1000, 4'b1100, 1'b1, 1000);  // csrrw + irq 3
    run_instr(7'b1110011, 3'd0, 2, 0, 4'b0000, 4'b0000, 1'b0, 1000);  // mret
    run_instr(7'b1100011, 3'd0, 0, 0, 4'b0000, 4'b0000, 1'b0, 1000);  // branch
    run_instr(7'b0000011, 3'd0, 0, 16, 4'b0000, 4'b0000, 1'b0, 1000); // load timeout
    run_instr(7'b0100011, 3'd0, 0, 0, 4'b0001, 4'b0001, 1'b1, 1000);  // sw 0-wait + irq 0
    run_instr(7'b0000011, 3'd2, 0, 10, 4'b0000, 4'b0000, 1'b0, 3);    // lw, abort in MEM_WAIT
    do_reset();
    run_random(250);

    // dut_b: timeout 3, legacy illegal handling
    sel = 1; m_to = 3; m_trap_en = 1'b0;
    do_reset();
    run_instr(7'b0000000, 3'd0, 0, 0, 4'b0000, 4'b0000, 1'b0, 1000);  // illegal -> INIT
    run_instr(7'b1110011, 3'd4, 1, 0, 4'b0000, 4'b0000, 1'b0, 1000);  // csr f3=100
    run_instr(7'b0110011, 3'd0, 5, 0, 4'b0000, 4'b0000, 1'b0, 1000);  // fetch timeout
    run_instr(7'b0110011, 3'd0, 3, 0, 4'b0000, 4'b0000, 1'b0, 1000);  // late ack loses
    run_instr(7'b0000011, 3'd0, 0, 4, 4'b0000, 4'b0000, 1'b0, 1000);  // load timeout
    run_instr(7'b0100011, 3'd0, 0, 3, 4'b0110, 4'b0100, 1'b1, 1000);  // sw 3-wait + irq 2
    run_random(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cu_fsm_mc.md
Name: cu_fsm_mc

Overview:
Parametrised multicycle control unit for the RISC-V OTTER, the successor to the fixed-timing control FSM. Adds memory wait-state handshaking on fetch, load and store, with a bus-error timeout. Adds a vector of maskable interrupt sources with fixed priority and a cause output. Traps illegal instructions instead of resetting the core. Sits between the instruction decoder, PC, register file, CSR file and memory.

Parameters:
NUM_IRQ, 4, number of interrupt request lines (1..16)
MEM_TIMEOUT, 15, max wait cycles for mem_ack before bus error; 0 = no timeout
ILLEGAL_TRAP_EN, 1, 1 = illegal instruction goes to TRAP; 0 = legacy (EXEC asserts FSM_reset, NS=INIT)

Ports:
FSM_clk  in  1  clock, rising edge
FSM_RST_n  in  1  reset, synchronous, active-low
FSM_opcode  in  7  instruction opcode
FSM_funct3  in  3  instruction funct3
FSM_irq  in  NUM_IRQ  level interrupt requests
FSM_irq_mask  in  NUM_IRQ  per-line enable (1 = enabled)
FSM_mie  in  1  global interrupt enable from CSR
mem_ack  in  1  memory completes the current request this cycle
FSM_pcWrite  out  1  PC load enable
FSM_regWrite  out  1  register file write enable
FSM_memWE2  out  1  data memory write
FSM_memRDEN1  out  1  instruction fetch read
FSM_memRDEN2  out  1  data memory read
FSM_reset  out  1  datapath reset
csr_WE  out  1  CSR write
int_taken  out  1  interrupt entry
int_cause  out  max(1,$clog2(NUM_IRQ))  index of serviced interrupt, registered
mret_exec  out  1  mret executing
trap_taken  out  1  synchronous trap entry
trap_cause  out  2  00 none, 01 illegal instruction, 10 bus error; registered
state_dbg  out  3  encoded present state

Behaviour:
- All outputs are decoded from the present state, except int_cause and trap_cause, which are registered. Strobes default to 0.
- Reset: FSM_RST_n=0 at a rising edge sets PS=INIT and clears the wait counter, int_cause and trap_cause.
- While in INIT: FSM_reset=1, all other strobes 0, state_dbg=0. INIT always goes to FETCH.
- States and encodings: INIT=0, FETCH=1, EXEC=2, MEM_WAIT=3, WB=4, INTR=5, TRAP=6.
- FETCH: memRDEN1=1 held every cycle until mem_ack=1, then NS=EXEC.
- mem_ack in the first cycle of a request means zero wait states; a fetch then takes exactly 1 FETCH cycle.
- Wait counter: increments on each FETCH or MEM_WAIT cycle with mem_ack=0, and clears on ack or state change.
- Timeout: if the counter reaches MEM_TIMEOUT with MEM_TIMEOUT>0, NS=TRAP and trap_cause<=10.
- EXEC, opcode 0110011 / 0010011 / 1100111 / 0110111 / 0010111 / 1101111: pcWrite=1, regWrite=1, then end-of-instruction.
- EXEC, opcode 1100011 (branch): pcWrite=1, then end-of-instruction.
- EXEC, opcode 1110011 with funct3=000 (mret): pcWrite=1, mret_exec=1, then end-of-instruction.
- EXEC, opcode 1110011 with funct3 in {001,010,011,101,110,111}: regWrite=1, csr_WE=1, pcWrite=1, then end-of-instruction. funct3=100 is illegal.
- EXEC, load 0000011: memRDEN2=1. If mem_ack, NS=WB; else NS=MEM_WAIT, which holds memRDEN2 until ack and then goes to WB.
- EXEC, store 0100011: memWE2=1. If mem_ack, pcWrite=1 in the same cycle, then end-of-instruction; else NS=MEM_WAIT.
- MEM_WAIT for a store holds memWE2; pcWrite=1 only in the ack cycle, then end-of-instruction.
- Load vs store in MEM_WAIT is tracked by an internal flag captured in EXEC.
- WB: pcWrite=1, regWrite=1, then end-of-instruction.
- End-of-instruction: pend = FSM_mie & |(FSM_irq & FSM_irq_mask).
  - If pend: NS=INTR and int_cause <= lowest set index of (FSM_irq & FSM_irq_mask).
  - Else: NS=FETCH.
- INTR: int_taken=1, pcWrite=1, NS=FETCH. int_cause is held until the next interrupt entry.
- Illegal instruction (unlisted opcode or CSR funct3=100):
  - ILLEGAL_TRAP_EN=1: NS=TRAP and trap_cause<=01, with no write strobes in that EXEC cycle.
  - ILLEGAL_TRAP_EN=0: FSM_reset=1 and NS=INIT.
- TRAP: trap_taken=1, pcWrite=1, NS=FETCH. Interrupts are not checked at TRAP exit; trap has priority.
- Simultaneous events:
  - Bus-error timeout beats a late ack in the same cycle; ack wins only if it arrives before the counter reaches MEM_TIMEOUT.
  - An irq change during MEM_WAIT is sampled only at end-of-instruction.
- Reset mid-operation: FSM_RST_n=0 during FETCH, MEM_WAIT or any other state gives PS=INIT at the next edge. All mem strobes are 0 in the following cycle, and no pcWrite/regWrite is issued for the aborted instruction.
- Undefined state encoding (7) goes to INIT.

Test Plan:
- Reset, then addi with mem_ack tied 1, irq=0: state sequence 0,1,2,1. pcWrite and regWrite both 1 for exactly the single EXEC cycle.
- lw with 3-cycle data ack delay: memRDEN2 high for 4 cycles (EXEC + 3 MEM_WAIT), then WB with pcWrite=regWrite=1, then FETCH.
- sw with ack on cycle 2: memWE2 high 2 cycles; pcWrite=1 only in the ack cycle; regWrite never 1.
- irq=4'b1010, mask=4'b1110, mie=1 during add EXEC: next state INTR, int_taken=1, int_cause=1, then FETCH. With mie=0: goes straight to FETCH.
- Fetch with mem_ack held 0, MEM_TIMEOUT=15: after 15 wait cycles PS=TRAP, trap_cause=10, trap_taken=1, then FETCH.
- opcode 0000000 with ILLEGAL_TRAP_EN=1 gives TRAP/trap_cause=01; with ILLEGAL_TRAP_EN=0 gives FSM_reset=1 and INIT. FSM_RST_n=0 during MEM_WAIT gives INIT next cycle with memRDEN2=0.
